// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: width defaults,
// FSM state encoding and access-owner encoding.
package mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU requester, I/O requester and memory-side signals.
// The arbiter uses the slave view; requesters and memory model use the master view.
interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_ack;
    logic [DW-1:0] io_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  io_req, io_we, io_addr, io_wdata,
        output io_ack, io_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output io_req, io_we, io_addr, io_wdata,
        input  io_ack, io_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_prio.sv
// CPU-priority winner select with a bounded-starvation counter for the I/O port.
// starve_cnt counts CPU grants made while I/O was waiting; at the limit I/O wins.
module mem_arb_prio #(
    parameter int MAX_CPU_BURST = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cpu_req,
    input  logic       io_req,
    input  logic       grant_en,
    output logic       win_io,
    output logic [3:0] starve_cnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CPU_BURST);

    logic [3:0] starve_cnt_reg;

    assign win_io     = io_req & (~cpu_req | (starve_cnt_reg == MAX_CNT));
    assign starve_cnt = starve_cnt_reg;

    // grant_en already implies a request is being granted this cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt_reg <= 4'd0;
        end else if (grant_en) begin
            if (win_io || !io_req) begin
                starve_cnt_reg <= 4'd0;
            end else if (starve_cnt_reg < MAX_CNT) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the CPU's single-port memory: issue in IDLE,
// acknowledge and return read data in RESP, one access every two cycles.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    mem_port_arbiter_if.slave   bus
);

    state_t        state_reg, state_next;
    owner_t        owner_reg, owner_next;
    logic          any_req;
    logic          grant_en;
    logic          win_io;
    logic [3:0]    starve_cnt;
    logic [1:0]    ack_vec;

    logic          mem_en_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic [DW-1:0] cpu_rdata_c;
    logic [DW-1:0] io_rdata_c;

    assign any_req  = bus.cpu_req | bus.io_req;
    assign grant_en = (state_reg == ST_IDLE) & any_req & ~RESET;

    mem_arb_prio #(
        .MAX_CPU_BURST (MAX_CPU_BURST)
    ) u_prio (
        .CLK        (CLK),
        .RESET      (RESET),
        .cpu_req    (bus.cpu_req),
        .io_req     (bus.io_req),
        .grant_en   (grant_en),
        .win_io     (win_io),
        .starve_cnt (starve_cnt)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_CPU;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_RESP;
                    owner_next = win_io ? OWN_IO : OWN_CPU;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset held during RESP suppresses the ack and drops the pending read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            localparam owner_t OWN_GI = (gi == 1) ? OWN_IO : OWN_CPU;
            assign ack_vec[gi] = (state_reg == ST_RESP) && (owner_reg == OWN_GI) && !RESET;
        end
    endgenerate

    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        cpu_rdata_c = '0;
        io_rdata_c  = '0;
        if (grant_en) begin
            mem_en_c = 1'b1;
            if (win_io) begin
                mem_we_c    = bus.io_we;
                mem_addr_c  = bus.io_addr;
                mem_wdata_c = bus.io_wdata;
            end else begin
                mem_we_c    = bus.cpu_we;
                mem_addr_c  = bus.cpu_addr;
                mem_wdata_c = bus.cpu_wdata;
            end
        end
        if (ack_vec[0]) begin
            cpu_rdata_c = bus.mem_rdata;
        end
        if (ack_vec[1]) begin
            io_rdata_c = bus.mem_rdata;
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.cpu_ack   = ack_vec[0];
    assign bus.io_ack    = ack_vec[1];
    assign bus.cpu_rdata = cpu_rdata_c;
    assign bus.io_rdata  = io_rdata_c;
    assign bus.cpu_stall = bus.cpu_req & ~ack_vec[0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-port op queues drive requests,
// expected results are queued at issue and compared when each ack appears.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } op_t;

    typedef struct {
        logic        we;
        logic [15:0] data;
    } exp_t;

    logic CLK;
    logic RESET;
    logic init_mem;

    logic [15:0] tb_mem  [0:255];
    logic [15:0] ref_mem [0:255];

    op_t  cpu_ops[$];
    op_t  io_ops[$];
    exp_t cpu_exp[$];
    exp_t io_exp[$];
    int   cpu_waits[$];
    int   grant_log[$];

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus();

    mem_port_arbiter #(
        .AW            (16),
        .DW            (16),
        .MAX_CPU_BURST (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_word(input int i);
        logic [15:0] w;
        w = 16'hA000 + 16'(i * 3);
        if (i == 16) w = 16'hBEEF;
        return w;
    endfunction

    // Synchronous-read memory model
    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= tb_mem[bus.mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (bus.cpu_ack && bus.io_ack) chk("dual_ack", 1, 0);
        if (bus.cpu_ack) begin
            grant_log.push_back(0);
            chk("io_rdata_nonowner", 32'(bus.io_rdata), 0);
            if (cpu_exp.size() == 0) chk("cpu_unexpected_ack", 1, 0);
            else begin
                e = cpu_exp.pop_front();
                $display("cpu ack we=%0d rdata=%h", e.we, bus.cpu_rdata);
                if (!e.we) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
            end
        end
        if (bus.io_ack) begin
            grant_log.push_back(1);
            chk("cpu_rdata_nonowner", 32'(bus.cpu_rdata), 0);
            if (io_exp.size() == 0) chk("io_unexpected_ack", 1, 0);
            else begin
                e = io_exp.pop_front();
                $display("io  ack we=%0d rdata=%h", e.we, bus.io_rdata);
                if (!e.we) chk("io_rdata", 32'(bus.io_rdata), 32'(e.data));
            end
        end
    end

    task automatic drive_cpu();
        op_t op;
        int  waited;
        while (cpu_ops.size() > 0) begin
            op = cpu_ops.pop_front();
            bus.cpu_req = 1'b1; bus.cpu_we = op.we;
            bus.cpu_addr = op.addr; bus.cpu_wdata = op.wdata;
            if (op.we) begin
                ref_mem[op.addr[7:0]] = op.wdata;
                cpu_exp.push_back('{1'b1, op.wdata});
            end else cpu_exp.push_back('{1'b0, ref_mem[op.addr[7:0]]});
            waited = 0;
            do begin @(negedge CLK); waited++; end while (!bus.cpu_ack && waited < 40);
            if (!bus.cpu_ack) chk("cpu_ack_timeout", 0, 1);
            cpu_waits.push_back(waited);
            @(posedge CLK); #1;
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic drive_io();
        op_t op;
        int  waited;
        while (io_ops.size() > 0) begin
            op = io_ops.pop_front();
            bus.io_req = 1'b1; bus.io_we = op.we;
            bus.io_addr = op.addr; bus.io_wdata = op.wdata;
            if (op.we) begin
                ref_mem[op.addr[7:0]] = op.wdata;
                io_exp.push_back('{1'b1, op.wdata});
            end else io_exp.push_back('{1'b0, ref_mem[op.addr[7:0]]});
            waited = 0;
            do begin @(negedge CLK); waited++; end while (!bus.io_ack && waited < 40);
            if (!bus.io_ack) chk("io_ack_timeout", 0, 1);
            chk("io_wait_bound", 32'(waited <= 10), 1);
            @(posedge CLK); #1;
        end
        bus.io_req = 1'b0;
    endtask

    initial begin
        int exp_pat[10];
        exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        RESET = 1'b1; init_mem = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.io_req  = 0; bus.io_we  = 0; bus.io_addr  = 0; bus.io_wdata  = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Requests during reset must not reach memory
        @(posedge CLK); #1;
        init_mem = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        bus.io_req = 1'b1;  bus.io_addr = 16'h0020;
        @(negedge CLK);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        @(posedge CLK); #1;
        bus.cpu_req = 1'b0; bus.io_req = 1'b0; RESET = 1'b0;
        @(negedge CLK);
        chk("idle_mem_en", 32'(bus.mem_en), 0);
        chk("idle_io_ack", 32'(bus.io_ack), 0);
        chk("idle_cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("idle_starve_cnt", 32'(dut.u_prio.starve_cnt_reg), 0);

        // CPU-only read of 0x0010
        @(posedge CLK); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        cpu_exp.push_back('{1'b0, 16'hBEEF});
        @(negedge CLK);
        chk("t1_mem_en", 32'(bus.mem_en), 1);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("t1_mem_we", 32'(bus.mem_we), 0);
        chk("t1_stall_n", 32'(bus.cpu_stall), 1);
        chk("t1_ack_n", 32'(bus.cpu_ack), 0);
        @(negedge CLK);
        chk("t1_ack_n1", 32'(bus.cpu_ack), 1);
        chk("t1_rdata_n1", 32'(bus.cpu_rdata), 32'hBEEF);
        chk("t1_stall_n1", 32'(bus.cpu_stall), 0);
        chk("t1_mem_en_n1", 32'(bus.mem_en), 0);
        @(posedge CLK); #1;
        bus.cpu_req = 1'b0;
        @(negedge CLK);
        chk("t1_ack_n2", 32'(bus.cpu_ack), 0);

        // I/O write then CPU read of the same address
        io_ops.push_back('{1'b1, 16'h0020, 16'h1234});
        drive_io();
        cpu_ops.push_back('{1'b0, 16'h0020, 16'h0000});
        drive_cpu();
        chk("t2_ref_word", 32'(ref_mem[32]), 32'h1234);

        // Reset arriving while a CPU read is in RESP
        @(posedge CLK); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
        @(negedge CLK);
        chk("t3_issue", 32'(bus.mem_en), 1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("t3_no_ack", 32'(bus.cpu_ack), 0);
        chk("t3_io_ack", 32'(bus.io_ack), 0);
        chk("t3_mem_en", 32'(bus.mem_en), 0);
        chk("t3_mem_we", 32'(bus.mem_we), 0);
        chk("t3_mem_addr", 32'(bus.mem_addr), 0);
        chk("t3_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("t3_cpu_rdata", 32'(bus.cpu_rdata), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        cpu_exp.push_back('{1'b0, ref_mem[1]});
        @(negedge CLK);
        chk("t3_reissue", 32'(bus.mem_en), 1);
        chk("t3_reissue_addr", 32'(bus.mem_addr), 1);
        @(negedge CLK);
        chk("t3_ack", 32'(bus.cpu_ack), 1);
        @(posedge CLK); #1;
        bus.cpu_req = 1'b0;

        // Back-to-back CPU reads, ack every 2 cycles
        cpu_waits.delete();
        for (int i = 0; i < 3; i++) cpu_ops.push_back('{1'b0, 16'(i), 16'h0});
        drive_cpu();
        chk("t4_count", 32'(cpu_waits.size()), 3);
        foreach (cpu_waits[i]) chk("t4_latency", 32'(cpu_waits[i]), 2);

        // Simultaneous requests from reset and the starvation bound
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        grant_log.delete();
        for (int i = 0; i < 8; i++) cpu_ops.push_back('{1'b0, 16'(i), 16'h0});
        io_ops.push_back('{1'b0, 16'h0040, 16'h0});
        io_ops.push_back('{1'b0, 16'h0041, 16'h0});
        fork
            drive_cpu();
            drive_io();
            begin
                @(negedge CLK);
                @(negedge CLK);
                chk("t5_first_win_cpu", 32'(bus.cpu_ack), 1);
                chk("t5_starve_cnt", 32'(dut.u_prio.starve_cnt_reg), 1);
            end
        join
        chk("t5_grants", 32'(grant_log.size()), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < grant_log.size()) chk("t5_pattern", 32'(grant_log[i]), 32'(exp_pat[i]));
        end
        chk("t5_cpu_drained", 32'(cpu_exp.size()), 0);
        chk("t5_io_drained", 32'(io_exp.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port unified memory between the multicycle ControlUnit datapath (instruction fetch, load/store, stack pushes/pops) and the I/O loader port (program download and display readback). Arbitration is CPU-priority with a bounded-starvation guarantee for I/O. Each granted access is a two-cycle issue/response transaction. `cpu_stall` freezes the ControlUnit state register while its access is pending.

## Interface
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `MAX_CPU_BURST`, default 4: consecutive CPU grants allowed while `io_req` is waiting; range 1..15.

- `CLK` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request, held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out DW: read data, valid only while `cpu_ack`=1.
- `cpu_stall` out 1: equals `cpu_req & ~cpu_ack`.
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_ack`, `io_rdata`: I/O requester port, same meaning and widths as the CPU port.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable; only meaningful while `mem_en`=1.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: synchronous-read data, valid the cycle after `mem_en`.

## Operation
- FSM states:
  - IDLE (reset state): if any request is present, assert `mem_en` and drive `mem_we`/`mem_addr`/`mem_wdata` combinationally from the winner, latch `owner`, and go to RESP. With no request, stay in IDLE with `mem_en`=0.
  - RESP: pulse `ack` to `owner`, route `mem_rdata` to that owner's `rdata`, and return to IDLE. `mem_en`=0 in RESP.
- Winner selection in IDLE:
  - Only one request present: that requester wins.
  - Both present and `starve_cnt` < `MAX_CPU_BURST`: CPU wins.
  - Both present and `starve_cnt` == `MAX_CPU_BURST`: I/O wins.
- `starve_cnt` (4 bits):
  - Increments on each CPU grant made while `io_req`=1.
  - Clears on an I/O grant.
  - Clears on any CPU grant made with `io_req`=0.
  - Saturates at `MAX_CPU_BURST`.
- Requester rules:
  - `addr`/`we`/`wdata` must be stable from `req` rise through the `ack` cycle.
  - `req` may stay high after `ack` to request a back-to-back access with new fields presented in the cycle after `ack`.
  - Dropping `req` before `ack` is illegal; behaviour is undefined.
- Non-owner `rdata` outputs are driven 0. `ack` is never asserted to both requesters in the same cycle.
- Reset values: state=IDLE, `owner`=CPU, `starve_cnt`=0, `cpu_ack`=`io_ack`=0, `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, both `rdata`=0. While `RESET`=1, all memory outputs are forced 0 regardless of `req`.
- Reset asserted in RESP: no `ack` is issued and the pending read is discarded. A held `req` is re-arbitrated in the first IDLE cycle after `RESET` falls. A write already issued has committed to memory.

## Timing
- Cycle N (IDLE, `req` seen): `mem_en`=1 for the winner. Cycle N+1 (RESP): `ack`=1, `rdata` valid. Cycle N+2: next arbitration.
- Latency is 2 cycles from `req` to `ack` with no contention. Peak throughput is one access per 2 cycles.
- Worst-case I/O wait is 2·`MAX_CPU_BURST` + 2 cycles from `io_req` to `io_ack`.
- `cpu_stall` is combinational from `cpu_req` and the registered `ack`, so the ControlUnit sees the stall in the same cycle it raises `cpu_req`.
- `ack` and `owner` are registered. Memory outputs are combinational from inputs in IDLE only, and 0 in RESP.

## Structure
- Shared package `mem_pkg`: `AW`/`DW` defaults, state encoding (ST_IDLE=0, ST_RESP=1), owner encoding (OWN_CPU=0, OWN_IO=1).
- Sub-module `mem_arb_prio`: combinational winner select plus the `starve_cnt` register, with inputs `cpu_req`, `io_req`, `grant_en` and output `win_io`.
- The top level holds the FSM, the request mux and the response demux.

## Test plan
- CPU-only read: `cpu_addr`=0x0010 with memory preloaded 0xBEEF; require `mem_en` in cycle N, `cpu_ack`=1 and `cpu_rdata`=0xBEEF at N+1, and `cpu_stall` high only in cycle N.
- I/O write then CPU read of the same address: I/O writes 0x1234 to 0x0020, then CPU reads 0x0020; require `cpu_rdata`=0x1234.
- Starvation bound: `cpu_req` and `io_req` held continuously with `MAX_CPU_BURST`=4; require the grant pattern CPU,CPU,CPU,CPU,IO repeating, with `io_ack` by cycle 10.
- Simultaneous first request: both requests rise in the same cycle from reset; require the CPU to win and `starve_cnt`=1 afterwards.
- Reset in RESP: assert `RESET` during a CPU read; require no `cpu_ack`, all outputs 0, and with `cpu_req` still held, re-issue on the first cycle after `RESET` falls, completing 2 cycles later.
- Back-to-back CPU: `cpu_req` held with the address changing after each `ack` (0x0,0x1,0x2); require an `ack` every 2 cycles and correct data for each address.
